if_weight_loader: RTL and testbench

- Configuration sequencer that programs the synaptic weight memory of `if_network` through its `mem_addr`/`mem_din`/`mem_wen` port.
- Accepts a valid/ready stream of weights and auto-generates packed addresses, neuron-major with input index fastest.
- Optionally reads back every written location through `mem_dout` and checks a running checksum.
- Sits between the host/DMA weight stream and `if_network`; the network runs spikes only after `done`.

---
 rtl/if_weight_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_if_weight_loader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_weight_loader.sv
// Weight-memory configuration sequencer for if_network: streams weights into packed
// {layer, neuron, weight} addresses and optionally verifies them with a readback checksum.
module if_weight_loader #(
    parameter int WEIGHT_SIZE       = 32,
    parameter int LAYER_ADDR_WIDTH  = 32,
    parameter int NEURON_ADDR_WIDTH = 28,
    parameter int WEIGHT_ADDR_WIDTH = 10,
    parameter int MAX_NEURONS       = 1024
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic                                           abort,
    input  logic [LAYER_ADDR_WIDTH-NEURON_ADDR_WIDTH-1:0]  cfg_layer,
    input  logic [NEURON_ADDR_WIDTH-WEIGHT_ADDR_WIDTH:0]   cfg_num_neurons,
    input  logic [WEIGHT_ADDR_WIDTH:0]                     cfg_num_inputs,
    input  logic                                           cfg_verify,
    input  logic                                           w_valid,
    output logic                                           w_ready,
    input  logic [WEIGHT_SIZE-1:0]                         w_data,
    output logic [LAYER_ADDR_WIDTH-1:0]                    mem_addr,
    output logic [WEIGHT_SIZE-1:0]                         mem_din,
    output logic                                           mem_wen,
    input  logic [WEIGHT_SIZE-1:0]                         mem_dout,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           verify_ok,
    output logic                                           cfg_err
);

    localparam int LAYER_W = LAYER_ADDR_WIDTH - NEURON_ADDR_WIDTH;
    localparam int NIDX_W  = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
    localparam int NCNT_W  = NIDX_W + 1;
    localparam int WCNT_W  = WEIGHT_ADDR_WIDTH + 1;

    localparam logic [NCNT_W-1:0] MAX_N = NCNT_W'(MAX_NEURONS);
    localparam logic [WCNT_W-1:0] MAX_W = {1'b1, {WEIGHT_ADDR_WIDTH{1'b0}}};
    localparam logic [NCNT_W-1:0] N_ONE = {{(NCNT_W-1){1'b0}}, 1'b1};
    localparam logic [WCNT_W-1:0] W_ONE = {{(WCNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    state_r;
    logic [LAYER_W-1:0]        layer_r;
    logic [NCNT_W-1:0]         num_neurons_r;
    logic [WCNT_W-1:0]         num_inputs_r;
    logic                      verify_r;
    logic [NCNT_W-1:0]         n_idx_r;
    logic [WCNT_W-1:0]         w_idx_r;
    logic [WEIGHT_SIZE-1:0]    wsum_r;
    logic [WEIGHT_SIZE-1:0]    rsum_r;
    logic                      rd_pres_r;
    logic                      rd_data_r;
    logic                      chk_r;
    logic [LAYER_ADDR_WIDTH-1:0] mem_addr_r;
    logic [WEIGHT_SIZE-1:0]    mem_din_r;
    logic                      mem_wen_r;
    logic                      done_r;
    logic                      verify_ok_r;
    logic                      cfg_err_r;

    logic                      w_last_s;
    logic                      last_s;
    logic                      cfg_illegal_s;
    logic                      cfg_zero_s;
    logic [LAYER_ADDR_WIDTH-1:0] cur_addr_s;
    logic [WEIGHT_SIZE-1:0]    rsum_next_s;

    function automatic logic [LAYER_ADDR_WIDTH-1:0] pack_addr(
        input logic [LAYER_W-1:0]           layer,
        input logic [NIDX_W-1:0]            neuron,
        input logic [WEIGHT_ADDR_WIDTH-1:0] weight
    );
        return {layer, neuron, weight};
    endfunction

    assign w_last_s      = (w_idx_r == (num_inputs_r - W_ONE));
    assign last_s        = w_last_s && (n_idx_r == (num_neurons_r - N_ONE));
    assign cfg_illegal_s = (cfg_num_inputs > MAX_W) || (cfg_num_neurons > MAX_N);
    assign cfg_zero_s    = (cfg_num_inputs == '0) || (cfg_num_neurons == '0);
    assign cur_addr_s    = pack_addr(layer_r, n_idx_r[NIDX_W-1:0],
                                     w_idx_r[WEIGHT_ADDR_WIDTH-1:0]);
    // The read word for an address arrives two cycles after it is registered.
    assign rsum_next_s   = rd_data_r ? (rsum_r + mem_dout) : rsum_r;

    assign w_ready   = (state_r == S_WRITE);
    assign busy      = (state_r != S_IDLE);
    assign mem_addr  = mem_addr_r;
    assign mem_din   = mem_din_r;
    assign mem_wen   = mem_wen_r;
    assign done      = done_r;
    assign verify_ok = verify_ok_r;
    assign cfg_err   = cfg_err_r;

    // Sequencer state, counters, checksums and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            layer_r       <= '0;
            num_neurons_r <= '0;
            num_inputs_r  <= '0;
            verify_r      <= 1'b0;
            n_idx_r       <= '0;
            w_idx_r       <= '0;
            wsum_r        <= '0;
            rsum_r        <= '0;
            rd_pres_r     <= 1'b0;
            rd_data_r     <= 1'b0;
            chk_r         <= 1'b0;
            mem_addr_r    <= '0;
            mem_din_r     <= '0;
            mem_wen_r     <= 1'b0;
            done_r        <= 1'b0;
            verify_ok_r   <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            mem_wen_r <= 1'b0;
            done_r    <= 1'b0;
            rd_pres_r <= 1'b0;
            rd_data_r <= rd_pres_r;
            rsum_r    <= rsum_next_s;
            if (abort) begin
                state_r   <= S_IDLE;
                rd_data_r <= 1'b0;
                chk_r     <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            layer_r       <= cfg_layer;
                            num_neurons_r <= cfg_num_neurons;
                            num_inputs_r  <= cfg_num_inputs;
                            verify_r      <= cfg_verify;
                            n_idx_r       <= '0;
                            w_idx_r       <= '0;
                            wsum_r        <= '0;
                            rsum_r        <= '0;
                            chk_r         <= 1'b0;
                            if (cfg_illegal_s) begin
                                cfg_err_r   <= 1'b1;
                                verify_ok_r <= 1'b0;
                                done_r      <= 1'b1;
                                state_r     <= S_DONE;
                            end else if (cfg_zero_s) begin
                                cfg_err_r   <= 1'b0;
                                verify_ok_r <= 1'b1;
                                done_r      <= 1'b1;
                                state_r     <= S_DONE;
                            end else begin
                                cfg_err_r   <= 1'b0;
                                verify_ok_r <= 1'b0;
                                state_r     <= S_WRITE;
                            end
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_WRITE: begin
                        if (w_valid) begin
                            mem_addr_r <= cur_addr_s;
                            mem_din_r  <= w_data;
                            mem_wen_r  <= 1'b1;
                            wsum_r     <= wsum_r + w_data;
                            if (last_s) begin
                                n_idx_r <= '0;
                                w_idx_r <= '0;
                                if (verify_r) begin
                                    state_r <= S_READ;
                                end else begin
                                    verify_ok_r <= 1'b1;
                                    done_r      <= 1'b1;
                                    state_r     <= S_DONE;
                                end
                            end else if (w_last_s) begin
                                w_idx_r <= '0;
                                n_idx_r <= n_idx_r + N_ONE;
                            end else begin
                                w_idx_r <= w_idx_r + W_ONE;
                            end
                        end else begin
                            state_r <= S_WRITE;
                        end
                    end
                    S_READ: begin
                        mem_addr_r <= cur_addr_s;
                        rd_pres_r  <= 1'b1;
                        if (last_s) begin
                            state_r <= S_DRAIN;
                        end else if (w_last_s) begin
                            w_idx_r <= '0;
                            n_idx_r <= n_idx_r + N_ONE;
                        end else begin
                            w_idx_r <= w_idx_r + W_ONE;
                        end
                    end
                    S_DRAIN: begin
                        chk_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end
                    S_DONE: begin
                        // The last read word lands during the done cycle, so the
                        // compare settles on the edge that leaves DONE.
                        if (chk_r) begin
                            verify_ok_r <= (rsum_next_s == wsum_r);
                        end else begin
                            verify_ok_r <= verify_ok_r;
                        end
                        chk_r   <= 1'b0;
                        state_r <= S_IDLE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_weight_loader.sv
// Scoreboard bench for if_weight_loader: a reference model pushes expected writes and
// completion results; independent monitors pop and compare against the DUT outputs.
module tb_if_weight_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  cfg_layer = 4'd0;
    logic [18:0] cfg_num_neurons = 19'd0;
    logic [10:0] cfg_num_inputs = 11'd0;
    logic        cfg_verify = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [31:0] w_data = 32'd0;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wen;
    logic [31:0] mem_dout = 32'd0;
    logic        busy;
    logic        done;
    logic        verify_ok;
    logic        cfg_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic cfg_err;
        logic vok;
        logic chk_vok;
    } done_t;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [31:0] wts[$];
    logic [31:0] mem [logic [31:0]];
    bit          corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_count = 0;
    bit          done_pend = 1'b0;
    done_t       done_cur;

    if_weight_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_layer(cfg_layer), .cfg_num_neurons(cfg_num_neurons),
        .cfg_num_inputs(cfg_num_inputs), .cfg_verify(cfg_verify),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .mem_dout(mem_dout), .busy(busy), .done(done),
        .verify_ok(verify_ok), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Weight memory with one-cycle read latency and an optional corrupted location.
    always @(posedge clk) begin : memory_model
        logic [31:0] rd;
        rd = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
        if (corrupt_en && mem_addr == corrupt_addr) rd = rd ^ 32'h1;
        mem_dout <= rd;
        if (mem_wen) mem[mem_addr] = mem_din;
    end

    // Write monitor.
    always @(negedge clk) begin
        if (!rst && mem_wen) begin
            wr_t e;
            wr_count++;
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_din);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_din, e.data);
            end
        end
    end

    // Completion monitor: result flags are compared on the cycle after done.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_pend) begin
                done_pend = 1'b0;
                chk("cfg_err", {31'd0, cfg_err}, {31'd0, done_cur.cfg_err});
                if (done_cur.chk_vok) chk("verify_ok", {31'd0, verify_ok}, {31'd0, done_cur.vok});
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    done_cur  = exp_done.pop_front();
                    done_pend = 1'b1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: build the weight list, expected writes and expected verdict.
    task automatic plan(input logic [3:0] layer, input int nn, input int ni, input bit ver,
                        input int pattern, input bit push_done, input int limit);
        logic [31:0] sum_w, sum_r, val, addr;
        done_t d;
        wts.delete();
        sum_w = 32'd0;
        sum_r = 32'd0;
        for (int n = 0; n < nn; n++) begin
            for (int w = 0; w < ni; w++) begin
                if (pattern == 0) val = (w % 2 == 0) ? -(w + 1) : (w + 1);
                else val = $urandom;
                addr = (32'(layer) << 28) + 32'(n * 1024 + w);
                wts.push_back(val);
                if (n * ni + w < limit) exp_wr.push_back('{addr: addr, data: val});
                sum_w = sum_w + val;
                sum_r = sum_r + ((corrupt_en && addr == corrupt_addr) ? (val ^ 32'h1) : val);
            end
        end
        d.cfg_err = 1'b0;
        d.vok     = ver ? (sum_r == sum_w) : 1'b1;
        d.chk_vok = 1'b1;
        if (push_done) exp_done.push_back(d);
    endtask

    task automatic start_load(input logic [3:0] layer, input int nn, input int ni, input bit ver);
        @(posedge clk);
        #1;
        cfg_layer       = layer;
        cfg_num_neurons = 19'(nn);
        cfg_num_inputs  = 11'(ni);
        cfg_verify      = ver;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers wts[] in order; vmode 0 = always valid, 1 = toggling, 2 = random.
    task automatic stream(input int count, input int vmode, output int first, output int last,
                          output bit ok);
        int idx = 0;
        int t = 0;
        bit rdy;
        first = 0;
        last  = 0;
        while (idx < count && t < 4000) begin
            case (vmode)
                0: w_valid = 1'b1;
                1: w_valid = (t % 2 == 0);
                default: w_valid = 1'($urandom_range(0, 1));
            endcase
            w_data = wts[idx];
            rdy = w_ready;
            @(posedge clk);
            if (w_valid && rdy) begin
                if (idx == 0) first = t;
                last = t;
                idx++;
            end
            #1;
            t++;
        end
        w_valid = 1'b0;
        ok = (idx == count);
        if (!ok) chk("stream_timeout", 32'(idx), 32'(count));
    endtask

    task automatic wait_done();
        int k = 0;
        while (k < 100) begin
            @(negedge clk);
            if (done) break;
            k++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        idle(3);
    endtask

    task automatic run_full(input logic [3:0] layer, input int nn, input int ni, input bit ver,
                            input int pattern, input int vmode, input bit cor,
                            input logic [31:0] cor_addr);
        int first, last, lat, nm;
        bit ok;
        nm = nn * ni;
        corrupt_en   = cor;
        corrupt_addr = cor_addr;
        plan(layer, nn, ni, ver, pattern, 1'b1, nm);
        start_load(layer, nn, ni, ver);
        stream(nm, vmode, first, last, ok);
        if (ok) begin
            lat = 1;
            while (lat < 500) begin
                @(negedge clk);
                if (done) break;
                @(posedge clk);
                lat++;
            end
            chk("done_latency", 32'(lat), ver ? 32'(nm + 2) : 32'd1);
            if (vmode == 0) chk("accept_span", 32'(last - first), 32'(nm - 1));
            if (vmode == 1) chk("accept_span", 32'(last - first), 32'(2 * (nm - 1)));
        end
        idle(4);
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        corrupt_en = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_din"}, mem_din, 32'd0);
        chk({tag, "_mem_wen"}, {31'd0, mem_wen}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_w_ready"}, {31'd0, w_ready}, 32'd0);
        chk({tag, "_verify_ok"}, {31'd0, verify_ok}, 32'd0);
        chk({tag, "_cfg_err"}, {31'd0, cfg_err}, 32'd0);
    endtask

    initial begin
        int first, last, wc0;
        bit ok;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        idle(2);

        // Directed loads from the plan.
        run_full(4'd0, 4, 8, 1'b0, 0, 0, 1'b0, 32'd0);
        run_full(4'd0, 4, 8, 1'b1, 0, 0, 1'b0, 32'd0);
        run_full(4'd0, 4, 8, 1'b1, 0, 0, 1'b1, 32'h0000_0405);
        run_full(4'd3, 2, 3, 1'b0, 1, 1, 1'b0, 32'd0);

        // Illegal input count: error flag, done, no writes.
        wc0 = wr_count;
        exp_done.push_back('{cfg_err: 1'b1, vok: 1'b0, chk_vok: 1'b0});
        start_load(4'd1, 2, 1025, 1'b1);
        wait_done();
        chk("illegal_no_writes", 32'(wr_count - wc0), 32'd0);

        // Zero neurons: done, error cleared, verify_ok set, no writes.
        wc0 = wr_count;
        exp_done.push_back('{cfg_err: 1'b0, vok: 1'b1, chk_vok: 1'b1});
        start_load(4'd1, 0, 5, 1'b0);
        wait_done();
        chk("zero_no_writes", 32'(wr_count - wc0), 32'd0);

        // Abort after five accepts; the weight offered with abort is discarded.
        wc0 = wr_count;
        plan(4'd2, 3, 4, 1'b0, 1, 1'b0, 5);
        start_load(4'd2, 3, 4, 1'b0);
        stream(5, 0, first, last, ok);
        w_valid = 1'b1;
        w_data  = wts[5];
        abort   = 1'b1;
        @(posedge clk);
        #1;
        abort   = 1'b0;
        w_valid = 1'b0;
        idle(4);
        chk("abort_writes", 32'(wr_count - wc0), 32'd5);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_drained", 32'(exp_wr.size()), 32'd0);

        // Reset mid-write, then a fresh load restarts from index 0.
        plan(4'd5, 2, 4, 1'b0, 1, 1'b0, 3);
        start_load(4'd5, 2, 4, 1'b0);
        stream(3, 0, first, last, ok);
        @(negedge clk);
        #2;
        chk("pre_reset_drained", 32'(exp_wr.size()), 32'd0);
        rst = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_full(4'd5, 2, 4, 1'b1, 1, 0, 1'b0, 32'd0);

        // Randomized loads.
        for (int k = 0; k < 5; k++) begin
            run_full(4'($urandom_range(0, 15)), $urandom_range(1, 3), $urandom_range(1, 5),
                     1'($urandom_range(0, 1)), 1, 2, 1'b0, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
